// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared types and encodings for the multi-cycle MIPS controller:
//            FSM state enum, instruction class, opcode/funct values, ALU
//            control codes and ALU operand-select encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM states. The numeric values are visible on state_o for debug,
    // so they are pinned explicitly (IDLE must read as 0 out of reset).
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC_R  = 3'd3,
        ST_EXEC_I  = 3'd4,
        ST_EXEC_BR = 3'd5,
        ST_WB      = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    // Instruction class produced by the decoder.
    typedef enum logic [1:0] {
        CLS_R   = 2'd0,
        CLS_I   = 2'd1,
        CLS_BR  = 2'd2,
        CLS_ILL = 2'd3
    } instr_class_t;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;

    // R-type function codes (instr[5:0]).
    localparam logic [5:0] C_FN_SLL  = 6'b000000;
    localparam logic [5:0] C_FN_SRL  = 6'b000010;
    localparam logic [5:0] C_FN_SLLV = 6'b000100;
    localparam logic [5:0] C_FN_SRLV = 6'b000110;
    localparam logic [5:0] C_FN_ADD  = 6'b100000;
    localparam logic [5:0] C_FN_SUB  = 6'b100010;
    localparam logic [5:0] C_FN_AND  = 6'b100100;
    localparam logic [5:0] C_FN_OR   = 6'b100101;
    localparam logic [5:0] C_FN_SLT  = 6'b101010;

    // ALU control codes.
    localparam logic [3:0] C_ALU_AND = 4'b0000;
    localparam logic [3:0] C_ALU_OR  = 4'b0001;
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_SUB = 4'b0110;
    localparam logic [3:0] C_ALU_SLT = 4'b0111;
    localparam logic [3:0] C_ALU_SLL = 4'b1000;
    localparam logic [3:0] C_ALU_SRL = 4'b1001;

    // ALU operand A select.
    localparam logic [1:0] C_SRCA_PC    = 2'd0;
    localparam logic [1:0] C_SRCA_RS    = 2'd1;
    localparam logic [1:0] C_SRCA_SHAMT = 2'd2;

    // ALU operand B select.
    localparam logic [1:0] C_SRCB_RT   = 2'd0;
    localparam logic [1:0] C_SRCB_FOUR = 2'd1;
    localparam logic [1:0] C_SRCB_SEXT = 2'd2;
    localparam logic [1:0] C_SRCB_ZEXT = 2'd3;

    // Decoder result bundle.
    typedef struct packed {
        instr_class_t cls;
        logic [3:0]   alu_ctrl;
        logic [1:0]   src_a;
        logic [1:0]   src_b;
        logic         legal;
    } decode_t;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_alu_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_decode
// Purpose  : Purely combinational instruction classifier. Maps the opcode
//            and funct fields onto an instruction class, ALU control code,
//            operand selects and a legal flag.
// Ports    : i_opcode  in  6   instr[31:26]
//            i_funct   in  6   instr[5:0]
//            o_dec     out     decode_t {cls, alu_ctrl, src_a, src_b, legal}
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output decode_t    o_dec
);

    always_comb begin
        o_dec.cls      = CLS_ILL;
        o_dec.alu_ctrl = C_ALU_AND;
        o_dec.src_a    = C_SRCA_PC;
        o_dec.src_b    = C_SRCB_RT;
        o_dec.legal    = 1'b0;

        case (i_opcode)
            C_OP_RTYPE: begin
                o_dec.cls   = CLS_R;
                o_dec.legal = 1'b1;
                o_dec.src_a = C_SRCA_RS;
                o_dec.src_b = C_SRCB_RT;
                case (i_funct)
                    C_FN_ADD:  o_dec.alu_ctrl = C_ALU_ADD;
                    C_FN_SUB:  o_dec.alu_ctrl = C_ALU_SUB;
                    C_FN_AND:  o_dec.alu_ctrl = C_ALU_AND;
                    C_FN_OR:   o_dec.alu_ctrl = C_ALU_OR;
                    C_FN_SLT:  o_dec.alu_ctrl = C_ALU_SLT;
                    // Immediate shifts take the shift amount from shamt.
                    C_FN_SLL: begin
                        o_dec.alu_ctrl = C_ALU_SLL;
                        o_dec.src_a    = C_SRCA_SHAMT;
                    end
                    C_FN_SRL: begin
                        o_dec.alu_ctrl = C_ALU_SRL;
                        o_dec.src_a    = C_SRCA_SHAMT;
                    end
                    // Variable shifts take the shift amount from rs.
                    C_FN_SLLV: o_dec.alu_ctrl = C_ALU_SLL;
                    C_FN_SRLV: o_dec.alu_ctrl = C_ALU_SRL;
                    default: begin
                        o_dec.cls   = CLS_ILL;
                        o_dec.legal = 1'b0;
                        o_dec.src_a = C_SRCA_PC;
                    end
                endcase
            end
            C_OP_ADDI: begin
                o_dec.cls      = CLS_I;
                o_dec.legal    = 1'b1;
                o_dec.src_a    = C_SRCA_RS;
                o_dec.src_b    = C_SRCB_SEXT;
                o_dec.alu_ctrl = C_ALU_ADD;
            end
            C_OP_ORI: begin
                o_dec.cls      = CLS_I;
                o_dec.legal    = 1'b1;
                o_dec.src_a    = C_SRCA_RS;
                o_dec.src_b    = C_SRCB_ZEXT;
                o_dec.alu_ctrl = C_ALU_OR;
            end
            C_OP_BEQ: begin
                // Compare rs and rt by subtraction; the zero flag decides.
                o_dec.cls      = CLS_BR;
                o_dec.legal    = 1'b1;
                o_dec.src_a    = C_SRCA_RS;
                o_dec.src_b    = C_SRCB_RT;
                o_dec.alu_ctrl = C_ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule : mc_alu_decode
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Purpose  : Multi-cycle main controller for the MIPS datapath. Sequences
//            FETCH / DECODE / EXEC / WB, drives datapath selects and enables,
//            flags illegal encodings and counts retired instructions.
// Ports    : clk_i, rst_i (async, active-high)
//            imem_valid_i, instr_i[31:0], alu_zero_i
//            imem_req_o, ir_write_o, pc_write_o, pc_src_o
//            reg_write_o, reg_dst_o, alu_src_a_o[1:0], alu_src_b_o[1:0]
//            alu_ctrl_o[3:0], instr_done_o, err_o, state_o[2:0]
//            instr_cnt_o[CNT_W-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             imem_valid_i,
    input  logic [31:0]      instr_i,
    input  logic             alu_zero_i,
    output logic             imem_req_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_ctrl_o,
    output logic             instr_done_o,
    output logic             err_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    state_t           r_state;
    decode_t          r_dec;        // decode result captured at end of DECODE
    logic [CNT_W-1:0] r_instr_cnt;

    decode_t          w_dec;
    logic             w_instr_done;

    // Register, immediate and shamt fields are consumed by the datapath,
    // not by the controller.
    logic             w_unused_instr;
    assign w_unused_instr = ^instr_i[25:6];

    mc_alu_decode u_alu_decode (
        .i_opcode (instr_i[31:26]),
        .i_funct  (instr_i[5:0]),
        .o_dec    (w_dec)
    );

    // ------------------------------------------------------------------
    // State, captured decode and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_dec       <= '0;
            r_instr_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_valid_i) begin
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_dec <= w_dec;
                    if (!w_dec.legal) begin
                        r_state <= ST_ERR;
                    end else begin
                        case (w_dec.cls)
                            CLS_R:   r_state <= ST_EXEC_R;
                            CLS_I:   r_state <= ST_EXEC_I;
                            CLS_BR:  r_state <= ST_EXEC_BR;
                            default: r_state <= ST_ERR;
                        endcase
                    end
                end
                ST_EXEC_R:  r_state <= ST_WB;
                ST_EXEC_I:  r_state <= ST_WB;
                ST_EXEC_BR: r_state <= ST_FETCH;
                ST_WB:      r_state <= ST_FETCH;
                ST_ERR:     r_state <= ST_ERR;   // held until reset
                default:    r_state <= ST_IDLE;
            endcase

            // Free-running wrap; illegal instructions never reach a
            // retiring state so they are not counted.
            if (w_instr_done) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    // Retire happens in WB for R/I-type and in EXEC_BR for branches.
    assign w_instr_done = (r_state == ST_WB) || (r_state == ST_EXEC_BR);

    // ------------------------------------------------------------------
    // Output decode. Everything is a function of the state register except
    // the FETCH write enables (gated by imem_valid_i) and the branch PC
    // write (gated by alu_zero_i). Because the outputs decode directly
    // from r_state, an asynchronous reset drops every enable at once.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        alu_src_a_o  = C_SRCA_PC;
        alu_src_b_o  = C_SRCB_RT;
        alu_ctrl_o   = C_ALU_AND;
        err_o        = 1'b0;

        case (r_state)
            ST_FETCH: begin
                // PC + 4 is computed every FETCH cycle; it is only
                // committed together with the IR when the word is valid.
                imem_req_o  = 1'b1;
                alu_src_a_o = C_SRCA_PC;
                alu_src_b_o = C_SRCB_FOUR;
                alu_ctrl_o  = C_ALU_ADD;
                ir_write_o  = imem_valid_i;
                pc_write_o  = imem_valid_i;
                pc_src_o    = 1'b0;
            end
            ST_EXEC_R, ST_EXEC_I: begin
                alu_src_a_o = r_dec.src_a;
                alu_src_b_o = r_dec.src_b;
                alu_ctrl_o  = r_dec.alu_ctrl;
            end
            ST_EXEC_BR: begin
                alu_src_a_o = r_dec.src_a;
                alu_src_b_o = r_dec.src_b;
                alu_ctrl_o  = r_dec.alu_ctrl;
                pc_write_o  = alu_zero_i;
                pc_src_o    = 1'b1;
            end
            ST_WB: begin
                // Selects stay at their EXEC values so ALUOut is stable.
                alu_src_a_o = r_dec.src_a;
                alu_src_b_o = r_dec.src_b;
                alu_ctrl_o  = r_dec.alu_ctrl;
                reg_write_o = 1'b1;
                reg_dst_o   = (r_dec.cls == CLS_R);
            end
            ST_ERR: begin
                err_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign instr_done_o = w_instr_done;
    assign state_o      = r_state;
    assign instr_cnt_o  = r_instr_cnt;

endmodule : mc_control_fsm
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Purpose  : Directed self-checking bench for mc_control_fsm. Every output
//            is compared each checked cycle against hand-derived vectors.
//            The counter is instantiated narrow so the wrap is reachable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    localparam int TB_CNT_W = 4;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_SLL = 4'b1000;
    localparam logic [3:0] A_SRL = 4'b1001;

    logic                clk;
    logic                rst_i;
    logic                imem_valid_i;
    logic [31:0]         instr_i;
    logic                alu_zero_i;
    logic                imem_req_o;
    logic                ir_write_o;
    logic                pc_write_o;
    logic                pc_src_o;
    logic                reg_write_o;
    logic                reg_dst_o;
    logic [1:0]          alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [3:0]          alu_ctrl_o;
    logic                instr_done_o;
    logic                err_o;
    logic [2:0]          state_o;
    logic [TB_CNT_W-1:0] instr_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [TB_CNT_W-1:0] exp_cnt = '0;

    mc_control_fsm #(.CNT_W(TB_CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_valid_i (imem_valid_i),
        .instr_i      (instr_i),
        .alu_zero_i   (alu_zero_i),
        .imem_req_o   (imem_req_o),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .instr_done_o (instr_done_o),
        .err_o        (err_o),
        .state_o      (state_o),
        .instr_cnt_o  (instr_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {req, irw, pcw, pcs, rw, rd, src_a, src_b, alu, done, err, state}
    logic [18:0] obs;
    assign obs = {imem_req_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o,
                  reg_dst_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o,
                  instr_done_o, err_o, state_o};

    function automatic logic [18:0] ev(
        input logic [2:0] st, input logic req, input logic irw,
        input logic pcw, input logic pcs, input logic rw, input logic rd,
        input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] alu,
        input logic done, input logic err);
        return {req, irw, pcw, pcs, rw, rd, sa, sb, alu, done, err, st};
    endfunction

    // Inputs change 2 ns after a rising edge; checks land 1 ns later.
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [18:0] exp);
        #1;
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [TB_CNT_W-1:0] exp);
        #1;
        n_tests++;
        assert (instr_cnt_o === exp) else begin
            n_fail++;
            $error("FAIL %s: observed count %0d expected %0d", tag, instr_cnt_o, exp);
        end
    endtask

    // Entry: DUT in FETCH. Exit: DUT in FETCH of the following instruction.
    task automatic run_r(input string tag, input logic [31:0] ins,
                         input logic [1:0] sa, input logic [3:0] alu);
        instr_i = ins; imem_valid_i = 1'b1;
        chk({tag, "_fetch"}, ev(3'd1, 1,1,1,0,0,0, 2'd0, 2'd1, A_ADD, 0,0));
        next_cyc();
        chk({tag, "_decode"}, ev(3'd2, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,0));
        next_cyc();
        chk({tag, "_exec"}, ev(3'd3, 0,0,0,0,0,0, sa, 2'd0, alu, 0,0));
        next_cyc();
        chk({tag, "_wb"}, ev(3'd6, 0,0,0,0,1,1, sa, 2'd0, alu, 1,0));
        next_cyc();
        exp_cnt = exp_cnt + 1'b1;
        chk_cnt({tag, "_cnt"}, exp_cnt);
    endtask

    task automatic run_i(input string tag, input logic [31:0] ins,
                         input logic [1:0] sb, input logic [3:0] alu);
        instr_i = ins; imem_valid_i = 1'b1;
        chk({tag, "_fetch"}, ev(3'd1, 1,1,1,0,0,0, 2'd0, 2'd1, A_ADD, 0,0));
        next_cyc();
        chk({tag, "_decode"}, ev(3'd2, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,0));
        next_cyc();
        chk({tag, "_exec"}, ev(3'd4, 0,0,0,0,0,0, 2'd1, sb, alu, 0,0));
        next_cyc();
        chk({tag, "_wb"}, ev(3'd6, 0,0,0,0,1,0, 2'd1, sb, alu, 1,0));
        next_cyc();
        exp_cnt = exp_cnt + 1'b1;
        chk_cnt({tag, "_cnt"}, exp_cnt);
    endtask

    task automatic run_beq(input string tag, input logic zero);
        instr_i = 32'h1022_0003; imem_valid_i = 1'b1; alu_zero_i = 1'b0;
        chk({tag, "_fetch"}, ev(3'd1, 1,1,1,0,0,0, 2'd0, 2'd1, A_ADD, 0,0));
        next_cyc();
        chk({tag, "_decode"}, ev(3'd2, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,0));
        next_cyc();
        alu_zero_i = zero;
        chk({tag, "_exec"}, ev(3'd5, 0,0,zero,1,0,0, 2'd1, 2'd0, A_SUB, 1,0));
        next_cyc();
        alu_zero_i = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        chk({tag, "_next"}, ev(3'd1, 1,1,1,0,0,0, 2'd0, 2'd1, A_ADD, 0,0));
        chk_cnt({tag, "_cnt"}, exp_cnt);
    endtask

    initial begin
        rst_i = 1'b1; imem_valid_i = 1'b0; instr_i = '0; alu_zero_i = 1'b0;
        next_cyc();
        chk("reset", ev(3'd0, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,0));
        chk_cnt("reset_cnt", 4'd0);

        // Release reset: one IDLE clock, then FETCH.
        rst_i = 1'b0; imem_valid_i = 1'b1; instr_i = 32'h0022_1820;
        next_cyc();
        run_r("add",  32'h0022_1820, 2'd1, A_ADD);

        // Remaining R-type functions.
        run_r("sub",  32'h0022_1822, 2'd1, A_SUB);
        run_r("and",  32'h0022_1824, 2'd1, A_AND);
        run_r("or",   32'h0022_1825, 2'd1, A_OR);
        run_r("slt",  32'h0022_182A, 2'd1, A_SLT);
        run_r("nop",  32'h0000_0000, 2'd2, A_SLL);
        run_r("srl",  32'h0002_1842, 2'd2, A_SRL);
        run_r("sllv", 32'h0022_1804, 2'd1, A_SLL);
        run_r("srlv", 32'h0022_1806, 2'd1, A_SRL);

        // Immediates with imm16 = 0xFFFF.
        run_i("addi", 32'h2021_FFFF, 2'd2, A_ADD);
        run_i("ori",  32'h3421_FFFF, 2'd3, A_OR);

        // Branch taken and not taken, plus the alu_zero Mealy path.
        run_beq("beq_t", 1'b1);
        run_beq("beq_n", 1'b0);

        // Memory wait: three stalled FETCH cycles.
        imem_valid_i = 1'b0; instr_i = 32'h0022_1820;
        for (int i = 0; i < 3; i++) begin
            chk("fetch_wait", ev(3'd1, 1,0,0,0,0,0, 2'd0, 2'd1, A_ADD, 0,0));
            next_cyc();
        end
        run_r("add_wait", 32'h0022_1820, 2'd1, A_ADD);

        // Illegal opcode 0x3F.
        instr_i = 32'hFC00_0000; imem_valid_i = 1'b1;
        chk("ill_fetch", ev(3'd1, 1,1,1,0,0,0, 2'd0, 2'd1, A_ADD, 0,0));
        next_cyc();
        chk("ill_decode", ev(3'd2, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,0));
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            chk("ill_err", ev(3'd7, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,1));
            chk_cnt("ill_cnt", exp_cnt);
            next_cyc();
        end
        rst_i = 1'b1;
        chk("ill_reset", ev(3'd0, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,0));
        chk_cnt("ill_reset_cnt", 4'd0);
        exp_cnt = '0;
        next_cyc();
        rst_i = 1'b0;
        next_cyc();

        // Reset asserted mid-WB: enables drop without a clock edge.
        instr_i = 32'h0022_1820; imem_valid_i = 1'b1;
        chk("rwb_fetch", ev(3'd1, 1,1,1,0,0,0, 2'd0, 2'd1, A_ADD, 0,0));
        next_cyc();
        next_cyc();
        next_cyc();
        chk("rwb_wb", ev(3'd6, 0,0,0,0,1,1, 2'd1, 2'd0, A_ADD, 1,0));
        rst_i = 1'b1;
        chk("rwb_abort", ev(3'd0, 0,0,0,0,0,0, 2'd0, 2'd0, A_AND, 0,0));
        next_cyc();
        rst_i = 1'b0;
        next_cyc();
        chk_cnt("rwb_cnt", 4'd0);

        // Counter wrap on the narrow instance: 16 retires return it to 0.
        for (int i = 0; i < 15; i++) begin
            run_beq("wrap_step", 1'b0);
        end
        chk_cnt("wrap_full", 4'hF);
        run_beq("wrap_last", 1'b0);
        chk_cnt("wrap_zero", 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_mc_control_fsm
`default_nettype wire
